// File: rtl/avalon_st_pkg.sv
// rtl/avalon_st_pkg.sv - shared Avalon-ST sideband types and helpers
// Used by the upsizer and by avalon_sampler downstream.
package avalon_st_pkg;

  // Wide enough for the empty count of any practical RATIO.
  localparam int EMPTY_W_MAX = 8;

  function automatic int lane_cnt_w(input int ratio);
    return $clog2(ratio);
  endfunction

  typedef struct packed {
    logic                   sop;
    logic                   eop;
    logic [EMPTY_W_MAX-1:0] empty;
  } st_side_t;

endpackage

// File: rtl/avalon_st_upsizer_lane_counter.sv
// rtl/avalon_st_upsizer_lane_counter.sv - modulo-RATIO lane counter
// clr and inc together restart the count at 1 (new word whose lane 0 is being written).
module avalon_st_upsizer_lane_counter
  import avalon_st_pkg::*;
#(
  parameter int RATIO = 4,
  localparam int CW = lane_cnt_w(RATIO)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          last
);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_base;

  assign w_base = clr ? '0 : r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= (w_base == CW'(RATIO - 1)) ? '0 : w_base + CW'(1);
    end else begin
      r_count <= w_base;
    end
  end

  assign count = r_count;
  assign last  = (r_count == CW'(RATIO - 1));

endmodule

// File: rtl/avalon_st_upsizer.sv
// rtl/avalon_st_upsizer.sv - Avalon-ST width up-converter
// Packs RATIO input beats into one wide word; short final words carry an empty count.
module avalon_st_upsizer
  import avalon_st_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  input  logic                      in_sop,
  input  logic                      in_eop,
  output logic                      in_ready,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic                      out_valid,
  output logic                      out_sop,
  output logic                      out_eop,
  output logic [$clog2(RATIO)-1:0]  out_empty,
  input  logic                      out_ready,
  output logic                      err_sop
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CW    = lane_cnt_w(RATIO);

  generate
    if (RATIO < 2) begin : g_bad_ratio
      $fatal(1, "avalon_st_upsizer: RATIO must be >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_sop;
  logic             r_err_sop;
  st_side_t         r_side;

  logic [OUT_W-1:0] w_word;
  st_side_t         w_side;
  logic [CW-1:0]    w_cnt;
  logic [CW-1:0]    w_lane;
  logic             w_last;
  logic             w_fire;
  logic             w_complete;
  logic             w_word_sop;
  logic             w_unused_empty;

  assign in_ready   = ~r_out_valid | out_ready;
  assign w_fire     = in_valid & in_ready;
  // An sop beat always restarts at lane 0, dropping any partial word.
  assign w_lane     = in_sop ? '0 : w_cnt;
  assign w_complete = w_fire & (in_eop | (~in_sop & w_last));

  avalon_st_upsizer_lane_counter #(
    .RATIO (RATIO)
  ) u_lane_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_fire & ~in_eop),
    .clr   (w_fire & (in_sop | in_eop)),
    .count (w_cnt),
    .last  (w_last)
  );

  always_comb begin
    w_word = in_sop ? '0 : r_acc;
    for (int i = 0; i < RATIO; i++) begin
      if (w_lane == CW'(i)) begin
        w_word[i*IN_WIDTH +: IN_WIDTH] = in_data;
      end
    end
    w_word_sop  = (w_lane == '0) ? in_sop : r_sop;
    w_side       = '0;
    w_side.sop   = w_word_sop;
    w_side.eop   = in_eop;
    w_side.empty = EMPTY_W_MAX'(CW'(RATIO - 1) - w_lane);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc       <= '0;
      r_sop       <= 1'b0;
      r_err_sop   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_side      <= '0;
    end else begin
      r_err_sop <= w_fire & in_sop & (w_cnt != '0);
      if (w_fire) begin
        // Accumulator stays zero above the fill point, so completed words need no masking.
        if (w_complete) begin
          r_acc <= '0;
          r_sop <= 1'b0;
        end else begin
          r_acc <= w_word;
          r_sop <= w_word_sop;
        end
      end
      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_word;
        r_side      <= w_side;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign out_sop        = r_side.sop;
  assign out_eop        = r_side.eop;
  assign out_empty      = r_side.empty[CW-1:0];
  assign err_sop        = r_err_sop;
  assign w_unused_empty = ^r_side.empty;

endmodule

// File: tb/tb_avalon_st_upsizer.sv
// tb/tb_avalon_st_upsizer.sv - self-checking bench for avalon_st_upsizer
// Directed scenarios plus randomized packets checked against a queue-based packing model.
module tb_avalon_st_upsizer;

  localparam int IW = 8;
  localparam int R  = 4;
  localparam int OW = IW * R;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          in_eop = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_sop;
  logic          out_eop;
  logic [EW-1:0] out_empty;
  logic          out_ready = 1'b1;
  logic          err_sop;

  avalon_st_upsizer #(.IN_WIDTH(IW), .RATIO(R)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_empty (out_empty),
    .out_ready (out_ready),
    .err_sop   (err_sop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OW-1:0] data;
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
  } word_t;

  word_t         got_q[$];
  word_t         exp_q[$];
  logic [IW-1:0] pend[$];
  bit            pend_sop;
  int            tests = 0;
  int            fails = 0;
  int            err_seen = 0;
  int            exp_err = 0;
  int            cyc = 0;
  bit            rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    word_t w;
    #3;
    if (rst_n && out_valid && out_ready) begin
      w.data = out_data; w.sop = out_sop; w.eop = out_eop; w.empty = out_empty;
      got_q.push_back(w);
    end
    if (rst_n && err_sop) err_seen++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference packing: gather beats per word, emit on RATIO beats or eop.
  task automatic model_beat(input logic [IW-1:0] d, input bit s, input bit e);
    word_t w;
    if (s && pend.size() != 0) begin
      pend.delete();
      exp_err++;
    end
    if (pend.size() == 0) pend_sop = s;
    pend.push_back(d);
    if (pend.size() == R || e) begin
      w.data = '0;
      foreach (pend[i]) w.data |= OW'(pend[i]) << (IW * i);
      w.sop = pend_sop;
      w.eop = e;
      w.empty = EW'(R - pend.size());
      exp_q.push_back(w);
      pend.delete();
    end
  endtask

  task automatic drive(input logic [IW-1:0] d, input bit s, input bit e);
    bit acc = 0;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    for (int k = 0; k < 200 && !acc; k++) begin
      #1;
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (acc) model_beat(d, s, e);
    else chk("drive_timeout", 64'(acc), 64'd1);
  endtask

  task automatic compare_flush(input string tag);
    word_t g, x;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      x = exp_q.pop_front();
      chk({tag, "_word"}, {g.data, g.sop, g.eop, g.empty}, {x.data, x.sop, x.eop, x.empty});
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int start;
    int len;
    bit no_eop;
    bit no_sop;

    repeat (2) tick();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_side", {out_sop, out_eop, out_empty, err_sop}, 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 1; i <= 8; i++) begin
      drive(IW'(i), i == 1, i == 8);
      if (i == 4) begin
        chk("t1_w0_valid", 64'(out_valid), 64'd1);
        chk("t1_w0", {out_data, out_sop, out_eop, out_empty}, {32'h04030201, 1'b1, 1'b0, 2'd0});
      end
      if (i == 8) chk("t1_w1", {out_valid, out_data, out_sop, out_eop, out_empty},
                      {1'b1, 32'h08070605, 1'b0, 1'b1, 2'd0});
    end
    tick();
    compare_flush("t1");

    for (int i = 0; i < 6; i++) drive(IW'(8'hA0 + i), i == 0, i == 5);
    chk("t2_w1", {out_valid, out_data, out_eop, out_empty}, {1'b1, 32'h0000A5A4, 1'b1, 2'd2});
    tick();
    compare_flush("t2");

    drive(8'h5A, 1, 1);
    chk("t3_single", {out_valid, out_data, out_sop, out_eop, out_empty},
        {1'b1, 32'h0000005A, 1'b1, 1'b1, 2'd3});
    tick();
    compare_flush("t3");

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(IW'(8'hC0 + i), i == 0, 0);
    in_data = 8'hC4; in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("t4_stall_ready", 64'(in_ready), 64'd0);
      chk("t4_stall_hold", {out_valid, out_data}, {1'b1, 32'hC3C2C1C0});
      tick();
    end
    out_ready = 1'b1;
    drive(8'hC4, 0, 0);
    start = cyc;
    for (int i = 5; i <= 12; i++) drive(IW'(8'hC0 + i), 0, i == 12);
    chk("t4_rate", 64'(cyc - start), 64'd8);
    tick();
    compare_flush("t4");

    drive(8'h11, 0, 0);
    drive(8'h22, 0, 0);
    drive(8'h33, 1, 0);
    chk("t5_err_pulse", 64'(err_sop), 64'd1);
    tick();
    chk("t5_err_clear", 64'(err_sop), 64'd0);
    drive(8'h44, 0, 0);
    drive(8'h55, 0, 0);
    drive(8'h66, 0, 1);
    tick();
    chk("t5_word", 64'(got_q.size() == 1 ? got_q[0].data : '0), 64'h66554433);
    compare_flush("t5");
    chk("t5_err_count", 64'(err_seen), 64'(exp_err));

    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) drive(IW'(8'hD0 + i), i == 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6a_rst", {out_valid, in_ready, out_data}, {1'b0, 1'b1, 32'h0});
    chk("t6a_no_drain", 64'(got_q.size()), 64'd0);
    exp_q.delete(); pend.delete();
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    drive(8'hE0, 1, 0);
    drive(8'hE1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6b_rst", {out_valid, in_ready}, {1'b0, 1'b1});
    exp_q.delete(); pend.delete();
    tick();
    rst_n = 1'b1;
    tick();
    drive(8'hF0, 1, 0);
    drive(8'hF1, 0, 1);
    chk("t6b_lane0", {out_valid, out_data, out_sop, out_eop, out_empty},
        {1'b1, 32'h0000F1F0, 1'b1, 1'b1, 2'd2});
    tick();
    compare_flush("t6");
    err_seen = 0; exp_err = 0;

    rand_bp = 1;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 10);
      no_eop = ($urandom_range(0, 7) == 0);
      no_sop = ($urandom_range(0, 9) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) tick();
        drive(IW'($urandom), b == 0 && !no_sop, b == len - 1 && !no_eop);
      end
    end
    rand_bp = 0;
    tick();
    out_ready = 1'b1;
    repeat (5) tick();
    compare_flush("rand");
    chk("rand_err_count", 64'(err_seen), 64'(exp_err));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
